// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the external memory bus between the CPU core and
// one DMA requester, handing ownership over only at instruction boundaries.
module mem_bus_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int MIN_CPU   = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_n_oe,
  input  logic        cpu_n_we,
  input  logic        cpu_ir_we,
  output logic        cpu_hold,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_n_oe,
  output logic        mem_n_we
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int FW = (MIN_CPU > 0) ? $clog2(MIN_CPU + 1) : 1;

  typedef enum logic [1:0] {
    S_CPU,
    S_HOLD,
    S_DMA,
    S_REL
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_nx;
  logic [FW-1:0] fair_cnt;
  logic [FW-1:0] fair_nx;
  logic          hold_nx;
  logic          gnt_nx;
  logic          ack_nx;
  logic [7:0]    rdata_nx;
  logic          access;
  logic          burst_last;

  assign access     = (state == S_DMA) && dma_req;
  assign burst_last = (burst_cnt == BW'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_CPU;
      burst_cnt <= '0;
      fair_cnt  <= '0;
      cpu_hold  <= 1'b0;
      dma_gnt   <= 1'b0;
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_nx;
      fair_cnt  <= fair_nx;
      cpu_hold  <= hold_nx;
      dma_gnt   <= gnt_nx;
      dma_ack   <= ack_nx;
      dma_rdata <= rdata_nx;
    end
  end

  always_comb begin
    state_nx = state;
    burst_nx = burst_cnt;
    fair_nx  = fair_cnt;
    hold_nx  = cpu_hold;
    gnt_nx   = dma_gnt;
    ack_nx   = access;
    rdata_nx = dma_rdata;
    if (access && !dma_we) begin
      rdata_nx = mem_rdata;
    end
    unique case (state)
      S_CPU: begin
        if (cpu_ir_we) begin
          if (fair_cnt != '0) begin
            fair_nx = fair_cnt - 1'b1;
          end else if (dma_req) begin
            state_nx = S_HOLD;
            hold_nx  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        state_nx = S_DMA;
        gnt_nx   = 1'b1;
        burst_nx = '0;
      end
      S_DMA: begin
        if (access) begin
          burst_nx = burst_cnt + 1'b1;
        end
        // an idle request cycle or the capped access ends the burst
        if (!dma_req || burst_last) begin
          state_nx = S_REL;
          gnt_nx   = 1'b0;
        end
      end
      S_REL: begin
        state_nx = S_CPU;
        hold_nx  = 1'b0;
        fair_nx  = FW'(MIN_CPU);
      end
      default: begin
        state_nx = S_CPU;
      end
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_n_oe  = cpu_n_oe;
    mem_n_we  = cpu_n_we;
    unique case (state)
      S_CPU: begin
      end
      S_HOLD, S_REL: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_n_oe  = 1'b1;
        mem_n_we  = 1'b1;
      end
      S_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_n_oe  = ~(dma_req & ~dma_we);
        // write strobe only in the low half, like a CPU store
        mem_n_we  = ~(dma_req & dma_we) | clk;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random and directed traffic against a timeline model
// of bus ownership derived from queue length, burst cap and boundaries.
module tb_mem_bus_arbiter;

  localparam int MAXB = 4;
  localparam int MINC = 2;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } acc_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_n_oe;
  logic        cpu_n_we;
  logic        cpu_ir_we;
  logic        cpu_hold;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_n_oe;
  logic        mem_n_we;

  logic        d0_hold;
  logic        d0_req;
  logic        d0_irw;
  logic        d0_gnt;
  logic        d0_ack;
  logic [7:0]  d0_rdata;
  logic [15:0] d0_maddr;
  logic [7:0]  d0_mwdata;
  logic        d0_noe;
  logic        d0_nwe;

  always #5 clk = ~clk;

  function automatic logic [7:0] memfn(logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign mem_rdata = memfn(mem_addr);

  mem_bus_arbiter #(.MAX_BURST(MAXB), .MIN_CPU(MINC)) u_dut (
    .clk(clk), .n_rst(n_rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_n_oe(cpu_n_oe), .cpu_n_we(cpu_n_we),
    .cpu_ir_we(cpu_ir_we), .cpu_hold(cpu_hold),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_n_oe(mem_n_oe), .mem_n_we(mem_n_we)
  );

  mem_bus_arbiter #(.MAX_BURST(MAXB), .MIN_CPU(0)) u_dut0 (
    .clk(clk), .n_rst(n_rst),
    .cpu_addr(16'h0100), .cpu_wdata(8'h00),
    .cpu_n_oe(1'b1), .cpu_n_we(1'b1),
    .cpu_ir_we(d0_irw), .cpu_hold(d0_hold),
    .dma_req(d0_req), .dma_we(1'b1),
    .dma_addr(16'h4000), .dma_wdata(8'h77),
    .dma_gnt(d0_gnt), .dma_ack(d0_ack), .dma_rdata(d0_rdata),
    .mem_addr(d0_maddr), .mem_wdata(d0_mwdata), .mem_rdata(8'h00),
    .mem_n_oe(d0_noe), .mem_n_we(d0_nwe)
  );

  int n_chk = 0;
  int n_fail = 0;

  // model state: pending requests and the current ownership window
  acc_t       q[$];
  int         cyc = 0;
  int         win_t = -1;
  int         win_n = 0;
  int         win_l = 0;
  int         fair = 0;
  logic [7:0] exp_rdata = 8'h00;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic bit busy(int c);
    return win_t >= 0 && c >= win_t && c <= win_t + win_l + 1;
  endfunction

  function automatic bit is_gnt(int c);
    return win_t >= 0 && c >= win_t + 1 && c <= win_t + win_l;
  endfunction

  function automatic bit is_acc(int c);
    return win_t >= 0 && c >= win_t + 1 && c <= win_t + win_n;
  endfunction

  function automatic bit is_ack(int c);
    return win_t >= 0 && c >= win_t + 2 && c <= win_t + win_n + 1;
  endfunction

  task automatic drive_dma();
    if (q.size() > 0) begin
      dma_req   = 1'b1;
      dma_we    = q[0].we;
      dma_addr  = q[0].addr;
      dma_wdata = q[0].data;
    end else begin
      dma_req = 1'b0;
    end
  endtask

  // advance the model across the posedge closing cycle cyc
  task automatic edge_update();
    acc_t a;
    int   c;
    c = cyc;
    if (is_acc(c)) begin
      a = q.pop_front();
      if (!a.we) exp_rdata = memfn(a.addr);
    end else if (!busy(c) && cpu_ir_we) begin
      if (fair == 0 && q.size() > 0) begin
        win_t = c + 1;
        win_n = (q.size() < MAXB) ? q.size() : MAXB;
        win_l = win_n + ((q.size() < MAXB) ? 1 : 0);
      end else if (fair > 0) begin
        fair--;
      end
    end
    if (win_t >= 0 && c + 1 == win_t + win_l + 2) fair = MINC;
    cyc = c + 1;
  endtask

  task automatic check_hi();
    check("cpu_hold", cpu_hold, busy(cyc));
    check("dma_gnt", dma_gnt, is_gnt(cyc));
    check("dma_ack", dma_ack, is_ack(cyc));
    check("dma_rdata", dma_rdata, exp_rdata);
    if (!busy(cyc)) begin
      check("pt_addr", mem_addr, cpu_addr);
      check("pt_wdata", mem_wdata, cpu_wdata);
      check("pt_n_oe", mem_n_oe, cpu_n_oe);
      check("pt_n_we", mem_n_we, cpu_n_we);
    end else if (is_acc(cyc)) begin
      check("dma_addr", mem_addr, q[0].addr);
      check("dma_wdata", mem_wdata, q[0].data);
      check("dma_n_oe", mem_n_oe, q[0].we);
      check("dma_n_we_hi", mem_n_we, 1);
    end else begin
      check("idle_n_oe", mem_n_oe, 1);
      check("idle_n_we", mem_n_we, 1);
      if (cyc == win_t) check("hold_addr", mem_addr, q[0].addr);
    end
  endtask

  task automatic check_lo();
    if (is_acc(cyc)) begin
      check("dma_n_we_lo", mem_n_we, !q[0].we);
      check("dma_n_oe_lo", mem_n_oe, q[0].we);
    end else if (busy(cyc)) begin
      check("idle_n_we_lo", mem_n_we, 1);
      check("idle_n_oe_lo", mem_n_oe, 1);
    end else begin
      check("pt_n_we_lo", mem_n_we, cpu_n_we);
    end
  endtask

  // entered and left just after a posedge
  task automatic run_cycle(input bit irw, input bit rnd_push);
    acc_t a;
    cpu_addr  = 16'($urandom);
    cpu_wdata = 8'($urandom);
    cpu_n_oe  = 1'($urandom_range(0, 1));
    cpu_n_we  = 1'($urandom_range(0, 1));
    cpu_ir_we = irw;
    if (rnd_push && !busy(cyc) && $urandom_range(0, 5) == 0) begin
      a.we   = 1'($urandom_range(0, 1));
      a.addr = 16'($urandom);
      a.data = 8'($urandom);
      q.push_back(a);
    end
    drive_dma();
    #2;
    check_hi();
    @(negedge clk);
    #2;
    check_lo();
    @(posedge clk);
    #1;
    edge_update();
  endtask

  initial begin
    bit found;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_n_oe  = 1'b1;
    cpu_n_we  = 1'b1;
    cpu_ir_we = 1'b0;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = 16'h0000;
    dma_wdata = 8'h00;
    d0_req    = 1'b0;
    d0_irw    = 1'b0;

    #12;
    check("rst_hold", cpu_hold, 0);
    check("rst_gnt", dma_gnt, 0);
    check("rst_ack", dma_ack, 0);
    check("rst_rdata", dma_rdata, 0);
    check("rst_n_we", mem_n_we, cpu_n_we);
    check("rst_addr", mem_addr, cpu_addr);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;

    q.push_back('{we: 1'b0, addr: 16'h1234, data: 8'h00});
    run_cycle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0);

    q.push_back('{we: 1'b1, addr: 16'h8000, data: 8'h3C});
    for (int i = 1; i < 6; i++)
      q.push_back('{we: 1'b1, addr: 16'(16'h8000 + i), data: 8'(8'h3C + i)});
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0);

    for (int i = 0; i < 800; i++)
      run_cycle($urandom_range(0, 3) == 0, 1'b1);

    for (int i = 0; i < 300 && (q.size() > 0 || busy(cyc)); i++)
      run_cycle(1'b1, 1'b0);
    check("drain", q.size(), 0);

    q.delete();
    for (int i = 0; i < 3; i++)
      q.push_back('{we: 1'b1, addr: 16'(16'hC000 + i), data: 8'(8'h90 + i)});
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (is_acc(cyc) && q[0].we) found = 1'b1;
      else run_cycle(1'b1, 1'b0);
    end
    check("mid_reach", found, 1);
    if (found) begin
      cpu_n_we  = 1'b1;
      cpu_n_oe  = 1'b1;
      cpu_ir_we = 1'b0;
      drive_dma();
      @(negedge clk);
      #2;
      check("mid_we_low", mem_n_we, 0);
      n_rst = 1'b0;
      #1;
      check("mid_we_rise", mem_n_we, 1);
      check("mid_hold", cpu_hold, 0);
      check("mid_gnt", dma_gnt, 0);
      check("mid_ack", dma_ack, 0);
      check("mid_addr", mem_addr, cpu_addr);
    end
    n_rst = 1'b0;
    q.delete();
    win_t = -1;
    fair = 0;
    exp_rdata = 8'h00;
    drive_dma();
    @(posedge clk);
    #3;
    check("mid_rst_ack", dma_ack, 0);
    check("mid_rst_rdata", dma_rdata, 0);
    check("mid_rst_hold", cpu_hold, 0);
    @(negedge clk);
    n_rst = 1'b1;

    @(posedge clk);
    #1;
    d0_req = 1'b1;
    d0_irw = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(posedge clk);
      #3;
      check("m0_hold", d0_hold, (k % 7) != 6);
      check("m0_gnt", d0_gnt, (k % 7) >= 1 && (k % 7) <= 4);
      check("m0_ack", d0_ack, (k % 7) >= 2 && (k % 7) <= 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
